// File: rtl/mmul_arbiter.sv
// Round-robin front end sharing one mmul2 engine among N requesters.
// Latches the winner's operands, waits for completion (or watchdog) and returns C.
module mmul_arbiter #(
    parameter int unsigned RA  = 3,
    parameter int unsigned CA  = 2,
    parameter int unsigned RB  = 2,
    parameter int unsigned CB  = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned N   = 2,
    parameter int unsigned TMO = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*RA*CA*W-1:0]  a_in,
    input  logic [N*RB*CB*W-1:0]  b_in,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          done,
    output logic                  err,
    output logic [RA*CB*W-1:0]    c_out,
    output logic                  busy,
    output logic                  eng_enable,
    output logic [RA*CA*W-1:0]    eng_a,
    output logic [RB*CB*W-1:0]    eng_b,
    input  logic [RA*CB*W-1:0]    eng_c,
    input  logic                  eng_completed
);

    localparam int unsigned AW = RA * CA * W;
    localparam int unsigned BW = RB * CB * W;
    localparam int unsigned CW = RA * CB * W;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TMO);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            en_q, en_d;
    logic [CW-1:0]   c_q, c_d;
    logic [AW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            wd_expired;

    assign wd_expired = (wd_q == TW'(TMO - 1));

    // Round-robin search starting one past the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_q) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_RUN;
            S_RUN:   if (eng_completed || wd_expired) state_d = S_DRAIN;
            S_DRAIN: if (!eng_completed) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        err_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        en_d   = en_q;
        c_d    = c_q;
        a_d    = a_q;
        b_d    = b_q;
        last_d = last_q;
        wd_d   = wd_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    a_d    = a_in[32'(win_idx) * AW +: AW];
                    b_d    = b_in[32'(win_idx) * BW +: BW];
                    gnt_d  = N'(1) << win_idx;
                    en_d   = 1'b1;
                    last_d = win_idx;
                    wd_d   = '0;
                end
            end
            S_RUN: begin
                wd_d = wd_q + TW'(1);
                if (eng_completed) begin
                    c_d    = eng_c;
                    done_d = N'(1) << last_q;
                    en_d   = 1'b0;
                end else if (wd_expired) begin
                    done_d = N'(1) << last_q;
                    err_d  = 1'b1;
                    en_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(N - 1);
            wd_q   <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            en_q   <= 1'b0;
            c_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            last_q <= last_d;
            wd_q   <= wd_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            en_q   <= en_d;
            c_q    <= c_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign eng_enable = en_q;
    assign c_out      = c_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;

endmodule
